// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared core constants and the IF/ID bundle type
package fetch_unit_pkg;

  localparam int          DEFAULT_ADDR_W    = 32;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'd0;
  localparam logic [31:0] DEFAULT_PC_STEP   = 32'd1;
  // RV32I addi x0,x0,0
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic                      valid;
    logic [DEFAULT_ADDR_W-1:0] pc;
    logic [31:0]               instr;
  } if_id_t;

endpackage

// File: rtl/fetch_unit_program_counter.sv
// rtl/fetch_unit_program_counter.sv - next-fetch PC register with step/redirect/hold select
module fetch_unit_program_counter
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(DEFAULT_PC_STEP)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // The target itself is issued this cycle, so the register skips ahead past it.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_target + PC_STEP;
    end else if (!stall) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: memory address, request tracking, IF/ID register
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W    = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
  parameter logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(DEFAULT_PC_STEP),
  parameter logic [31:0]       NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_instr
);

  logic [ADDR_W-1:0] pc;

  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] req_pc_q,    req_pc_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_pc_q,    out_pc_d;
  logic [31:0]       out_instr_q, out_instr_d;

  fetch_unit_program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_program_counter (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc              (pc)
  );

  always_comb begin
    imem_addr   = pc;
    req_valid_d = req_valid_q;
    req_pc_d    = req_pc_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    if (redirect_valid) begin
      // Whatever is in flight is wrong-path; kill it and start on the target.
      imem_addr   = redirect_target;
      req_valid_d = 1'b1;
      req_pc_d    = redirect_target;
      out_valid_d = 1'b0;
      out_instr_d = NOP_INSTR;
    end else if (stall) begin
      // Re-read the pending word so imem_data still matches req_pc_q on release.
      imem_addr = req_pc_q;
    end else begin
      req_valid_d = 1'b1;
      req_pc_d    = pc;
      out_valid_d = req_valid_q;
      out_pc_d    = req_pc_q;
      out_instr_d = req_valid_q ? imem_data : NOP_INSTR;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= NOP_INSTR;
    end else begin
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector table plus randomized run against a stream-level reference model
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instr       (out_instr)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  // Synchronous-read memory; garbage while reset is held.
  always @(posedge clock) begin
    imem_data <= reset ? 32'hxxxx_xxxx : mem_word(imem_addr);
  end

  // Reference model: next address to fetch, the single word in flight, and what decode sees.
  logic [31:0] m_next;
  bit          m_inflight;
  logic [31:0] m_inflight_pc;
  bit          m_ov;
  logic [31:0] m_opc;
  logic [31:0] m_oinstr;
  logic [31:0] m_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic s, input logic rv, input logic [31:0] t);
    if (r) begin
      m_next = 32'd0; m_inflight = 0; m_inflight_pc = 32'd0;
      m_ov = 0; m_oinstr = NOP;
    end else if (rv) begin
      m_ov = 0; m_oinstr = NOP;
      m_inflight = 1; m_inflight_pc = t; m_next = t + 32'd1;
    end else if (!s) begin
      m_ov = m_inflight;
      if (m_inflight) begin
        m_opc = m_inflight_pc;
        m_oinstr = mem_word(m_inflight_pc);
      end else begin
        m_oinstr = NOP;
      end
      m_inflight = 1; m_inflight_pc = m_next; m_next = m_next + 32'd1;
    end
  endtask

  // Drive one cycle's inputs, sample the combinational address, then clock and settle.
  task automatic cycle(input logic r, input logic s, input logic rv, input logic [31:0] t,
                       output logic [31:0] addr_seen);
    reset = r; stall = s; redirect_valid = rv; redirect_target = t;
    #1;
    addr_seen = imem_addr;
    m_addr = rv ? t : (s ? m_inflight_pc : m_next);
    model_edge(r, s, rv, t);
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic stl, input logic rv, input logic [31:0] tgt,
                              input logic [31:0] addr, input logic v, input logic [31:0] pc,
                              input logic [31:0] instr);
    vec_t x;
    x.rst = rst; x.stl = stl; x.rv = rv; x.tgt = tgt;
    x.addr = addr; x.v = v; x.pc = pc; x.instr = instr;
    return x;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [31:0] a;
    logic        r, s, rv;
    logic [31:0] t;

    //             rst  stl  rv   tgt            addr           v    pc             instr
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd0,        0, 32'd0,        NOP));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd1,        1, 32'd0,        32'hA000_0000));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd2,        1, 32'd1,        32'hA000_0001));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd3,        1, 32'd2,        32'hA000_0002));
    tbl.push_back(mk(0, 1, 0, 32'd0,        32'd3,        1, 32'd2,        32'hA000_0002));
    tbl.push_back(mk(0, 1, 0, 32'd0,        32'd3,        1, 32'd2,        32'hA000_0002));
    tbl.push_back(mk(0, 1, 0, 32'd0,        32'd3,        1, 32'd2,        32'hA000_0002));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd4,        1, 32'd3,        32'hA000_0003));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd5,        1, 32'd4,        32'hA000_0004));
    tbl.push_back(mk(0, 0, 1, 32'd20,       32'd20,       0, 32'd0,        NOP));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd21,       1, 32'd20,       32'hA000_0014));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd22,       1, 32'd21,       32'hA000_0015));
    tbl.push_back(mk(0, 1, 1, 32'd8,        32'd8,        0, 32'd0,        NOP));
    tbl.push_back(mk(0, 1, 0, 32'd0,        32'd8,        0, 32'd0,        NOP));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd9,        1, 32'd8,        32'hA000_0008));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd10,       1, 32'd9,        32'hA000_0009));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd11,       1, 32'd10,       32'hA000_000A));
    tbl.push_back(mk(1, 0, 0, 32'd0,        32'd12,       0, 32'd0,        NOP));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd0,        0, 32'd0,        NOP));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd1,        1, 32'd0,        32'hA000_0000));
    tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd0,      NOP));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd0,        1, 32'hFFFF_FFFF, 32'h9FFF_FFFF));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd1,        1, 32'd0,        32'hA000_0000));
    tbl.push_back(mk(1, 0, 0, 32'd0,        32'd2,        0, 32'd0,        NOP));
    tbl.push_back(mk(0, 0, 1, 32'd40,       32'd40,       0, 32'd0,        NOP));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd41,       1, 32'd40,       32'hA000_0028));
    tbl.push_back(mk(1, 1, 0, 32'd0,        32'd41,       0, 32'd0,        NOP));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd0,        0, 32'd0,        NOP));
    tbl.push_back(mk(0, 0, 0, 32'd0,        32'd1,        1, 32'd0,        32'hA000_0000));

    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    model_edge(1'b1, 1'b0, 1'b0, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_pc", out_pc, 32'd0);
    check("reset out_instr", out_instr, NOP);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].stl, tbl[i].rv, tbl[i].tgt, a);
      check($sformatf("vec%0d imem_addr", i), a, tbl[i].addr);
      check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].v});
      check($sformatf("vec%0d out_instr", i), out_instr, tbl[i].instr);
      if (tbl[i].v) check($sformatf("vec%0d out_pc", i), out_pc, tbl[i].pc);
    end

    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 63) == 0);
      rv = ($urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 3) == 0);
      t  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2))
                                       : 32'($urandom_range(0, 255));
      cycle(r, s, rv, t, a);
      check($sformatf("rnd%0d imem_addr", n), a, m_addr);
      check($sformatf("rnd%0d out_valid", n), {31'd0, out_valid}, {31'd0, m_ov});
      check($sformatf("rnd%0d out_instr", n), out_instr, m_oinstr);
      if (m_ov) check($sformatf("rnd%0d out_pc", n), out_pc, m_opc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
